// File: rtl/multi_dataflow_kernel_ctrl_fsm_pkg.sv
// Shared types and defaults for the multi_dataflow kernel control FSM.
// Optional watchdog build switch: MULTI_DATAFLOW_CTRL_TIMEOUT_EN.
package multi_dataflow_kernel_ctrl_fsm_pkg;

   localparam int unsigned CTRL_CNT_W_DEF       = 32'd16;
   localparam int unsigned CTRL_TIMEOUT_CYC_DEF = 32'd1024;

   typedef enum logic [2:0] {
      FSM_IDLE       = 3'd0,
      FSM_START      = 3'd1,
      FSM_WAIT_READY = 3'd2,
      FSM_WAIT_DONE  = 3'd3,
      FSM_FINISH     = 3'd4,
      FSM_DONE       = 3'd5
   } ctrl_fsm_state_t;

   // Job request as issued by the HWPE controller.
   typedef struct packed {
      logic                      start;
      logic [CTRL_CNT_W_DEF-1:0] n_out;
   } ctrl_engine_job_t;

   // Engine -> kernel adapter control.
   typedef struct packed {
      logic start;
   } ctrl_kernel_adapter_t;

   // Kernel adapter -> engine flags.
   typedef struct packed {
      logic ready;
      logic done;
      logic idle;
   } flags_kernel_adapter_t;

   // States in which the engine waits on the adapter (watchdog-supervised).
   function automatic logic is_wait_state(input ctrl_fsm_state_t st);
      logic res;
      case (st)
         FSM_WAIT_READY: res = 1'b1;
         FSM_WAIT_DONE:  res = 1'b1;
         FSM_FINISH:     res = 1'b1;
         default:        res = 1'b0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/multi_dataflow_ctrl_watchdog.sv
// Cycle watchdog for the kernel control FSM wait states.
// Only instantiated when MULTI_DATAFLOW_CTRL_TIMEOUT_EN is defined.
module multi_dataflow_ctrl_watchdog #(
   parameter int unsigned CNT_W       = 32'd16,
   parameter int unsigned TIMEOUT_CYC = 32'd1024
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clear_i,
   input  logic active_i,
   input  logic restart_i,
   output logic expired_o
);

   // Expiry is flagged during the TIMEOUT_CYC-th cycle spent in one state.
   localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(TIMEOUT_CYC - 32'd1);
   localparam logic [CNT_W-1:0] ONE      = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_nxt_s;

   // Next count: restart on any state change, saturate at the limit.
   always_comb begin
      cnt_nxt_s = cnt_r;
      if (clear_i || restart_i || !active_i) begin
         cnt_nxt_s = {CNT_W{1'b0}};
      end else if (cnt_r != LIMIT_M1) begin
         cnt_nxt_s = cnt_r + ONE;
      end else begin
         cnt_nxt_s = cnt_r;
      end
   end

   // Count register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_r <= {CNT_W{1'b0}};
      end else begin
         cnt_r <= cnt_nxt_s;
      end
   end

   assign expired_o = active_i && (cnt_r == LIMIT_M1);

endmodule

// File: rtl/multi_dataflow_kernel_ctrl_fsm.sv
// Engine-side start/flag controller for the multi_dataflow kernel adapter.
// Issues one start per output element, counts done handshakes against the
// programmed job length and pulses job_done_o at job end.
// Optional watchdog: define MULTI_DATAFLOW_CTRL_TIMEOUT_EN.
module multi_dataflow_kernel_ctrl_fsm
   import multi_dataflow_kernel_ctrl_fsm_pkg::*;
#(
   parameter int unsigned CNT_W       = CTRL_CNT_W_DEF,
   parameter int unsigned TIMEOUT_CYC = CTRL_TIMEOUT_CYC_DEF
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clear_i,
   input  logic             job_start_i,
   input  logic [CNT_W-1:0] n_out_i,
   output logic             kernel_start_o,
   input  logic             kernel_ready_i,
   input  logic             kernel_done_i,
   input  logic             kernel_idle_i,
   output logic             busy_o,
   output logic             job_done_o,
   output logic [CNT_W-1:0] out_cnt_o,
   output logic             err_o
);

   localparam logic [CNT_W-1:0] ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   ctrl_fsm_state_t       state_r, state_nxt_s;
   logic [CNT_W-1:0]      out_cnt_r, out_cnt_nxt_s;
   logic [CNT_W-1:0]      n_out_r, n_out_nxt_s;
   logic [CNT_W-1:0]      cnt_inc_s;
   logic                  err_r, err_nxt_s;
   logic                  wd_expired_s;
   flags_kernel_adapter_t flags_s;
   ctrl_kernel_adapter_t  ctrl_s;

   assign flags_s   = {kernel_ready_i, kernel_done_i, kernel_idle_i};
   assign cnt_inc_s = out_cnt_r + ONE;

`ifdef MULTI_DATAFLOW_CTRL_TIMEOUT_EN
   logic wd_active_s;
   logic wd_restart_s;

   assign wd_active_s  = is_wait_state(state_r);
   assign wd_restart_s = (state_nxt_s != state_r);

   multi_dataflow_ctrl_watchdog #(
      .CNT_W       (CNT_W),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_watchdog (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .clear_i   (clear_i),
      .active_i  (wd_active_s),
      .restart_i (wd_restart_s),
      .expired_o (wd_expired_s)
   );
`else
   assign wd_expired_s = 1'b0;
`endif

   // Next-state, counter, job-length latch and sticky error.
   always_comb begin
      state_nxt_s   = state_r;
      out_cnt_nxt_s = out_cnt_r;
      n_out_nxt_s   = n_out_r;
      err_nxt_s     = err_r;
      if (clear_i) begin
         state_nxt_s   = FSM_IDLE;
         out_cnt_nxt_s = ZERO;
         n_out_nxt_s   = ZERO;
         err_nxt_s     = 1'b0;
      end else if (wd_expired_s) begin
         state_nxt_s = FSM_DONE;
         err_nxt_s   = 1'b1;
      end else begin
         case (state_r)
            FSM_IDLE: begin
               if (job_start_i) begin
                  n_out_nxt_s   = n_out_i;
                  out_cnt_nxt_s = ZERO;
                  err_nxt_s     = flags_s.done;
                  state_nxt_s   = (n_out_i == ZERO) ? FSM_DONE : FSM_START;
               end else begin
                  err_nxt_s = err_r | flags_s.done;
               end
            end
            FSM_START: begin
               err_nxt_s   = err_r | flags_s.done;
               state_nxt_s = FSM_WAIT_READY;
            end
            FSM_WAIT_READY: begin
               if (flags_s.ready && flags_s.done) begin
                  out_cnt_nxt_s = cnt_inc_s;
                  state_nxt_s   = (cnt_inc_s == n_out_r) ? FSM_FINISH : FSM_START;
               end else if (flags_s.ready) begin
                  state_nxt_s = FSM_WAIT_DONE;
               end else begin
                  state_nxt_s = FSM_WAIT_READY;
               end
            end
            FSM_WAIT_DONE: begin
               if (flags_s.done) begin
                  out_cnt_nxt_s = cnt_inc_s;
                  state_nxt_s   = (cnt_inc_s == n_out_r) ? FSM_FINISH : FSM_START;
               end else begin
                  state_nxt_s = FSM_WAIT_DONE;
               end
            end
            FSM_FINISH: begin
               err_nxt_s   = err_r | flags_s.done;
               state_nxt_s = flags_s.idle ? FSM_DONE : FSM_FINISH;
            end
            FSM_DONE: begin
               err_nxt_s   = err_r | flags_s.done;
               state_nxt_s = FSM_IDLE;
            end
            default: begin
               state_nxt_s = FSM_IDLE;
            end
         endcase
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_r   <= FSM_IDLE;
         out_cnt_r <= ZERO;
         n_out_r   <= ZERO;
         err_r     <= 1'b0;
      end else begin
         state_r   <= state_nxt_s;
         out_cnt_r <= out_cnt_nxt_s;
         n_out_r   <= n_out_nxt_s;
         err_r     <= err_nxt_s;
      end
   end

   // Moore outputs decoded from the state register only.
   assign ctrl_s.start   = (state_r == FSM_START);
   assign kernel_start_o = ctrl_s.start;
   assign busy_o         = (state_r != FSM_IDLE);
   assign job_done_o     = (state_r == FSM_DONE);
   assign out_cnt_o      = out_cnt_r;
   assign err_o          = err_r;

endmodule

// File: tb/tb_multi_dataflow_kernel_ctrl_fsm.sv
// Bench for multi_dataflow_kernel_ctrl_fsm: adapter model, job scoreboard,
// directed corner cases and randomized jobs.
module tb_multi_dataflow_kernel_ctrl_fsm;

   localparam int CNT_W = 16;
   localparam int TO    = 16;

   logic             clk_i = 1'b0;
   logic             rst_ni;
   logic             clear_i;
   logic             job_start_i;
   logic [CNT_W-1:0] n_out_i;
   logic             kernel_start_o;
   logic             kernel_ready_i;
   logic             kernel_done_i;
   logic             kernel_idle_i;
   logic             busy_o;
   logic             job_done_o;
   logic [CNT_W-1:0] out_cnt_o;
   logic             err_o;

   logic adp_done, spur_done;
   logic adp_on, adp_same, adp_abort;
   int   adp_rdy_dly, adp_done_dly;

   assign kernel_done_i = adp_done | spur_done;

   typedef struct {
      int cnt;
      int err;
      int starts;
   } exp_t;
   exp_t sb_q[$];

   int n_checks = 0;
   int n_fail   = 0;

   multi_dataflow_kernel_ctrl_fsm #(.CNT_W(CNT_W), .TIMEOUT_CYC(TO)) dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .clear_i        (clear_i),
      .job_start_i    (job_start_i),
      .n_out_i        (n_out_i),
      .kernel_start_o (kernel_start_o),
      .kernel_ready_i (kernel_ready_i),
      .kernel_done_i  (kernel_done_i),
      .kernel_idle_i  (kernel_idle_i),
      .busy_o         (busy_o),
      .job_done_o     (job_done_o),
      .out_cnt_o      (out_cnt_o),
      .err_o          (err_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Adapter model: per start, ready after a delay, then done after a delay;
   // idle drops while an element is in flight and rises after its done.
   initial begin : adapter
      kernel_ready_i = 1'b0;
      adp_done       = 1'b0;
      kernel_idle_i  = 1'b1;
      forever begin
         @(negedge clk_i);
         if (kernel_start_o === 1'b1 && adp_on) begin
            kernel_idle_i = 1'b0;
            if (adp_same) begin
               @(posedge clk_i); #1;
               kernel_ready_i = 1'b1;
               adp_done       = 1'b1;
               @(posedge clk_i); #1;
               kernel_ready_i = 1'b0;
               adp_done       = 1'b0;
            end else begin
               repeat (adp_rdy_dly) @(posedge clk_i);
               #1 kernel_ready_i = 1'b1;
               @(posedge clk_i);
               #1 kernel_ready_i = 1'b0;
               for (int i = 0; i < adp_done_dly && !adp_abort; i++) @(posedge clk_i);
               #1;
               if (!adp_abort) begin
                  adp_done = 1'b1;
                  @(posedge clk_i);
                  #1 adp_done = 1'b0;
               end else begin
                  adp_done = 1'b0;
               end
            end
            kernel_idle_i = 1'b1;
         end
      end
   end

   // Monitor: counts start pulses, checks counter stepping, and pops the
   // scoreboard whenever the DUT signals job completion.
   initial begin : monitor
      int               starts;
      logic [CNT_W-1:0] prev;
      exp_t             e;
      starts = 0;
      prev   = '0;
      forever begin
         @(negedge clk_i);
         if (clear_i || !rst_ni) starts = 0;
         if (kernel_start_o === 1'b1) starts++;
         if (out_cnt_o != prev && out_cnt_o != '0)
            check("cnt_step", 32'(out_cnt_o), 32'(prev) + 32'd1);
         prev = out_cnt_o;
         if (job_done_o === 1'b1) begin
            if (sb_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_job_done: got job_done_o=1, expected no pending job (t=%0t)", $time);
            end else begin
               e = sb_q.pop_front();
               check("job_out_cnt", 32'(out_cnt_o), e.cnt);
               check("job_err", 32'(err_o), e.err);
               check("job_starts", starts, e.starts);
            end
            starts = 0;
         end
      end
   end

   task automatic wait_idle(input int budget);
      int k;
      k = 0;
      @(negedge clk_i);
      while (busy_o && k < budget) begin
         @(negedge clk_i);
         k++;
      end
      check("wait_idle_busy", 32'(busy_o), 32'd0);
   endtask

   task automatic issue_job(input int n);
      @(posedge clk_i); #1;
      job_start_i = 1'b1;
      n_out_i     = CNT_W'(n);
      @(posedge clk_i); #1;
      job_start_i = 1'b0;
      n_out_i     = CNT_W'($urandom);
   endtask

   task automatic run_job(input int n, input int rd, input int dd, input bit same, input bit poke);
      adp_rdy_dly  = rd;
      adp_done_dly = dd;
      adp_same     = same;
      sb_q.push_back('{cnt: n, err: 0, starts: n});
      issue_job(n);
      @(negedge clk_i);
      check("err_cleared_on_start", 32'(err_o), 32'd0);
      if (poke && n > 0) begin
         @(posedge clk_i); #1;
         job_start_i = 1'b1;
         n_out_i     = CNT_W'(n + 3);
         @(posedge clk_i); #1;
         job_start_i = 1'b0;
      end
      wait_idle(2000);
   endtask

   initial begin : guard
      #500000;
      $display("FAIL global_timeout: simulation did not finish, expected finish before 500000");
      $fatal(1, "timeout");
   end

   initial begin : main
      logic [CNT_W-1:0] saved_cnt;
      int               k;
      rst_ni       = 1'b0;
      clear_i      = 1'b0;
      job_start_i  = 1'b0;
      n_out_i      = '0;
      spur_done    = 1'b0;
      adp_on       = 1'b1;
      adp_same     = 1'b0;
      adp_abort    = 1'b0;
      adp_rdy_dly  = 2;
      adp_done_dly = 3;
      repeat (3) @(negedge clk_i);
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_start", 32'(kernel_start_o), 32'd0);
      check("rst_job_done", 32'(job_done_o), 32'd0);
      check("rst_out_cnt", 32'(out_cnt_o), 32'd0);
      check("rst_err", 32'(err_o), 32'd0);
      rst_ni = 1'b1;

      // Three outputs, ready 2 cycles after start, done 3 after ready.
      run_job(3, 2, 3, 1'b0, 1'b0);
      check("job3_err_after", 32'(err_o), 32'd0);

      // Zero-length job: DONE directly, job_done_o right after acceptance.
      sb_q.push_back('{cnt: 0, err: 0, starts: 0});
      issue_job(0);
      @(negedge clk_i);
      check("n0_job_done_now", 32'(job_done_o), 32'd1);
      check("n0_no_start", 32'(kernel_start_o), 32'd0);
      wait_idle(20);

      // Ready and done in the same cycle, single output.
      run_job(1, 1, 0, 1'b1, 1'b0);

      // Spurious done in IDLE: error set, count unchanged.
      saved_cnt = out_cnt_o;
      @(posedge clk_i); #1 spur_done = 1'b1;
      @(posedge clk_i); #1 spur_done = 1'b0;
      @(negedge clk_i);
      check("spur_err", 32'(err_o), 32'd1);
      check("spur_cnt_hold", 32'(out_cnt_o), 32'(saved_cnt));
      check("spur_idle", 32'(busy_o), 32'd0);
      run_job(2, 1, 1, 1'b0, 1'b0);

      // Clear in WAIT_DONE of a 5-output job at count 2.
      adp_rdy_dly  = 1;
      adp_done_dly = 12;
      adp_same     = 1'b0;
      issue_job(5);
      k = 0;
      while (out_cnt_o != CNT_W'(2) && k < 500) begin
         @(negedge clk_i);
         k++;
      end
      check("clr_reach_cnt2", 32'(out_cnt_o), 32'd2);
      repeat (5) @(negedge clk_i);
      @(posedge clk_i); #1;
      adp_abort = 1'b1;
      clear_i   = 1'b1;
      @(posedge clk_i); #1;
      clear_i = 1'b0;
      @(negedge clk_i);
      check("clr_busy", 32'(busy_o), 32'd0);
      check("clr_out_cnt", 32'(out_cnt_o), 32'd0);
      check("clr_no_job_done", 32'(job_done_o), 32'd0);
      check("clr_err", 32'(err_o), 32'd0);
      repeat (20) @(negedge clk_i);
      adp_abort = 1'b0;

      // Async reset mid-job.
      adp_rdy_dly  = 2;
      adp_done_dly = 6;
      issue_job(4);
      repeat (4) @(negedge clk_i);
      adp_abort = 1'b1;
      @(posedge clk_i); #2;
      rst_ni = 1'b0;
      #1;
      check("arst_busy", 32'(busy_o), 32'd0);
      check("arst_start", 32'(kernel_start_o), 32'd0);
      check("arst_out_cnt", 32'(out_cnt_o), 32'd0);
      @(negedge clk_i); #1;
      rst_ni = 1'b1;
      repeat (20) @(negedge clk_i);
      adp_abort = 1'b0;
      @(posedge clk_i); #1 clear_i = 1'b1;
      @(posedge clk_i); #1 clear_i = 1'b0;

      // Randomized jobs; one with a job_start issued mid-job that must be ignored.
      for (int j = 0; j < 10; j++) begin
         run_job($urandom_range(0, 6), $urandom_range(1, 3), $urandom_range(0, 3),
                 ($urandom_range(0, 3) == 0), (j == 2));
      end

`ifdef MULTI_DATAFLOW_CTRL_TIMEOUT_EN
      // Adapter never answers: watchdog fires 16 cycles into WAIT_READY.
      adp_on = 1'b0;
      sb_q.push_back('{cnt: 0, err: 1, starts: 1});
      issue_job(2);
      @(posedge clk_i);
      repeat (15) @(posedge clk_i);
      @(negedge clk_i);
      check("to_err_before", 32'(err_o), 32'd0);
      @(negedge clk_i);
      check("to_err_set", 32'(err_o), 32'd1);
      check("to_job_done", 32'(job_done_o), 32'd1);
      wait_idle(20);
      adp_on = 1'b1;
`endif

      repeat (5) @(negedge clk_i);
      check("sb_drained", sb_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
